// File: rtl/conc_trace_recorder.sv
// Captures DUT output samples ({speaker, nloss, nl}) into an internal trace
// memory, raw or run-length compressed, with a registered read-back port.
module conc_trace_recorder #(
  parameter  int DEPTH  = 64,
  parameter  int CNT_W  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              stop,
  input  logic              rle_en,
  input  logic              nloss,
  input  logic [3:0]        nl,
  input  logic              speaker,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W+5:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int                ENTRY_W    = CNT_W + 6;
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_reg;
  logic                mode_reg;
  logic                pend_valid_reg;
  logic [5:0]          pend_word_reg;
  logic [CNT_W-1:0]    pend_cnt_reg;
  logic [ADDR_W:0]     count_reg;
  logic                overflow_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [ENTRY_W-1:0]  rd_data_reg;

  logic [ENTRY_W-1:0]  mem [DEPTH];

  logic [5:0]          sample;
  logic                run_extends;
  logic                wr_en;
  logic [ENTRY_W-1:0]  wr_data;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W:0]     count_inc;
  logic                full_next;

  assign sample      = {speaker, nloss, nl};
  assign run_extends = pend_valid_reg && (sample == pend_word_reg) && (pend_cnt_reg != CNT_MAX);
  assign wr_addr     = count_reg[ADDR_W-1:0];
  assign count_inc   = count_reg + 1'b1;
  assign full_next   = wr_en && (count_inc == FULL_COUNT);

  // A write happens for every plain sample, for a closed RLE run, or for
  // the flush of a pending run when capture is stopped.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = {pend_cnt_reg, pend_word_reg};
    if (state_reg == CAPTURE) begin
      if (stop) begin
        wr_en = mode_reg && pend_valid_reg;
      end else if (!mode_reg) begin
        wr_en   = 1'b1;
        wr_data = {CNT_ONE, sample};
      end else begin
        wr_en = pend_valid_reg && !run_extends;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      mode_reg       <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_word_reg  <= '0;
      pend_cnt_reg   <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (arm) begin
            state_reg      <= CAPTURE;
            mode_reg       <= rle_en;
            pend_valid_reg <= 1'b0;
            pend_cnt_reg   <= '0;
            count_reg      <= '0;
            overflow_reg   <= 1'b0;
            busy_reg       <= 1'b1;
            done_reg       <= 1'b0;
          end
        end
        CAPTURE: begin
          if (wr_en) begin
            count_reg <= count_inc;
          end
          // stop takes priority over a full-making write in the same cycle
          if (stop) begin
            state_reg      <= DONE;
            pend_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
          end else if (full_next) begin
            state_reg      <= DONE;
            pend_valid_reg <= 1'b0;
            overflow_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b1;
          end else if (mode_reg) begin
            if (run_extends) begin
              pend_cnt_reg <= pend_cnt_reg + 1'b1;
            end else begin
              pend_valid_reg <= 1'b1;
              pend_word_reg  <= sample;
              pend_cnt_reg   <= CNT_ONE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Trace memory keeps its contents across reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data  = rd_data_reg;
  assign count    = count_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_conc_trace_recorder.sv
// Bench for conc_trace_recorder: directed capture scenarios with random
// sample streams, checked against a queue-based run-length reference model.
module tb_conc_trace_recorder;

  localparam int DEPTH  = 64;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 6;
  localparam int MAXRUN = (1 << CNT_W) - 1;

  logic              clock;
  logic              reset;
  logic              arm;
  logic              stop;
  logic              rle_en;
  logic              nloss;
  logic [3:0]        nl;
  logic              speaker;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W+5:0]  rd_data;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              overflow;

  conc_trace_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .arm      (arm),
    .stop     (stop),
    .rle_en   (rle_en),
    .nloss    (nloss),
    .nl       (nl),
    .speaker  (speaker),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model: accepted samples, and entries derived from them
  logic [5:0] samples [$];
  logic [5:0] exp_word [$];
  int         exp_cnt [$];
  bit         m_rle, m_active, m_done, m_ovf;
  int         m_count;
  logic [5:0] cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Entries implied by the accepted samples: one per sample in plain mode,
  // maximal runs (split at MAXRUN) in RLE mode.
  function automatic void build();
    exp_word.delete();
    exp_cnt.delete();
    foreach (samples[i]) begin
      if (!m_rle || exp_word.size() == 0 || samples[i] != exp_word[$] || exp_cnt[$] == MAXRUN) begin
        exp_word.push_back(samples[i]);
        exp_cnt.push_back(1);
      end else begin
        exp_cnt[exp_cnt.size()-1]++;
      end
    end
  endfunction

  // Entries already committed to memory while capture is running; in RLE
  // the last run is still pending.
  function automatic int written();
    build();
    if (!m_rle) return exp_word.size();
    return (exp_word.size() > 0) ? exp_word.size() - 1 : 0;
  endfunction

  function automatic logic [31:0] entry(input int a);
    logic [CNT_W+5:0] e;
    e = {CNT_W'(exp_cnt[a]), exp_word[a]};
    return 32'(e);
  endfunction

  // kind: 0 nl=k-1, 1 random with long runs, 2 constant nl=5,
  //       3 random every cycle, 4 nl=3 x5 then nl=7
  task automatic capture(input string name, input bit rle, input int ncyc, input int kind,
                         input int stop_cyc, input bit stop_arm, input int reset_cyc);
    int prev;
    int a;
    arm    = 1'b1;
    rle_en = rle;
    stop   = 1'b0;
    samples.delete();
    m_rle = rle; m_active = 1'b1; m_done = 1'b0; m_ovf = 1'b0; m_count = 0;
    cur = 6'($urandom);
    @(posedge clock); @(negedge clock);
    arm    = 1'b0;
    rle_en = 1'($urandom);
    check({name, " armed busy"}, 32'(busy), 32'd1);
    check({name, " armed done"}, 32'(done), 32'd0);
    check({name, " armed count"}, 32'(count), 32'd0);
    check({name, " armed overflow"}, 32'(overflow), 32'd0);
    for (int k = 1; k <= ncyc; k++) begin
      case (kind)
        0: cur = {2'b00, 4'(k - 1)};
        1: if ($urandom_range(0, 3) == 0) cur = 6'($urandom);
        2: cur = 6'd5;
        3: cur = 6'($urandom);
        default: cur = (k <= 5) ? 6'd3 : 6'd7;
      endcase
      {speaker, nloss, nl} = cur;
      stop    = (k == stop_cyc);
      arm     = stop_arm && stop;
      rd_addr = ADDR_W'((m_count > 0) ? $urandom_range(0, m_count - 1) : 0);
      prev    = m_count;
      if (k == reset_cyc) begin
        reset = 1'b1;
        #1;
        check({name, " reset busy"}, 32'(busy), 32'd0);
        check({name, " reset done"}, 32'(done), 32'd0);
        check({name, " reset count"}, 32'(count), 32'd0);
        check({name, " reset overflow"}, 32'(overflow), 32'd0);
        check({name, " reset rd_data"}, 32'(rd_data), 32'd0);
        @(negedge clock);
        reset = 1'b0; arm = 1'b0; stop = 1'b0;
        m_active = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_count = 0;
        $display("capture %s: reset after %0d samples", name, samples.size());
        return;
      end
      if (m_active) begin
        if (stop) begin
          build();
          m_count  = exp_word.size();
          m_active = 1'b0; m_done = 1'b1; m_ovf = 1'b0;
        end else begin
          samples.push_back(cur);
          m_count = written();
          if (m_count >= DEPTH) begin
            m_count  = DEPTH;
            m_active = 1'b0; m_done = 1'b1; m_ovf = 1'b1;
          end
        end
      end
      @(posedge clock); @(negedge clock);
      arm  = 1'b0;
      stop = 1'b0;
      check({name, " busy"}, 32'(busy), 32'(m_active));
      check({name, " count"}, 32'(count), 32'(m_count));
      if (int'(rd_addr) < prev) begin
        build();
        check({name, " live read"}, 32'(rd_data), entry(int'(rd_addr)));
      end
    end
    check({name, " done"}, 32'(done), 32'(m_done));
    check({name, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({name, " final count"}, 32'(count), 32'(m_count));
    build();
    for (int i = 0; i < m_count; i++) begin
      a = i;
      rd_addr = ADDR_W'(a);
      @(posedge clock); @(negedge clock);
      check({name, " readback"}, 32'(rd_data), entry(a));
    end
    $display("capture %s: rle=%0d samples=%0d entries=%0d overflow=%0d",
             name, rle, samples.size(), m_count, m_ovf);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; stop = 1'b0; rle_en = 1'b0;
    nloss = 1'b0; nl = 4'd0; speaker = 1'b0; rd_addr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset count", 32'(count), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);

    stop = 1'b1;
    @(posedge clock); @(negedge clock);
    stop = 1'b0;
    check("idle stop busy", 32'(busy), 32'd0);
    check("idle stop done", 32'(done), 32'd0);

    capture("plain_ramp", 1'b0, 11, 0, 11, 1'b0, 0);
    capture("rle_two_runs", 1'b1, 8, 4, 8, 1'b0, 0);
    capture("plain_full", 1'b0, 70, 3, 0, 1'b0, 0);
    capture("rle_saturate", 1'b1, 301, 2, 301, 1'b0, 0);
    capture("mid_reset", 1'b0, 20, 3, 0, 1'b0, 6);
    capture("rle_random", 1'b1, 150, 1, 150, 1'b0, 0);
    capture("rle_full", 1'b1, 200, 3, 0, 1'b0, 0);
    capture("plain_stop_at_full", 1'b0, 64, 3, 64, 1'b1, 0);
    capture("rle_stop_arm", 1'b1, 40, 1, 40, 1'b1, 0);

    repeat (3) @(negedge clock);
    check("done holds", 32'(done), 32'd1);
    check("busy stays low", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
